// File: rtl/alu_pkg.sv
// alu_pkg: shared widths, opcodes and request type for the ALU issue path
package alu_pkg;
    localparam int ALU_DATA_W = 32;
    localparam int ALU_OP_W   = 4;
    localparam logic [ALU_OP_W-1:0] ALU_ADD    = 4'd0;
    localparam logic [ALU_OP_W-1:0] ALU_SUB    = 4'd1;
    localparam logic [ALU_OP_W-1:0] ALU_AND    = 4'd2;
    localparam logic [ALU_OP_W-1:0] ALU_OR     = 4'd3;
    localparam logic [ALU_OP_W-1:0] ALU_SLL    = 4'd4;
    localparam logic [ALU_OP_W-1:0] ALU_ROTATE = 4'd5;
    typedef struct packed {
        logic [ALU_OP_W-1:0]   op;
        logic [ALU_DATA_W-1:0] src1;
        logic [ALU_DATA_W-1:0] src2;
    } alu_req_t;
endpackage

// File: rtl/alu_req_fifo.sv
// alu_req_fifo: DEPTH-entry request queue; level is the only full/empty source
module alu_req_fifo
    import alu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic                       pop,
    input  alu_req_t                   din,
    output alu_req_t                   head,
    output logic [$clog2(DEPTH+1)-1:0] level
);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH+1);
    alu_req_t mem [DEPTH];
    logic [PW-1:0] wptr, rptr;
    assign head = mem[rptr];
    // storage needs no reset: head is only observed while level is non-zero
    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= din;
    end
    // pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else begin
            if (push) wptr <= wptr + PW'(1);
            if (pop) rptr <= rptr + PW'(1);
            level <= level + LW'(push) - LW'(pop);
        end
    end
endmodule

// File: rtl/alu_issue_stage.sv
// alu_issue_stage: buffers ALU requests and registers results; ALU_ISSUE_OVF_TRAP_EN adds a sticky overflow halt
module alu_issue_stage
    import alu_pkg::*;
#(
    parameter int DATA_W = ALU_DATA_W,
    parameter int OP_W   = ALU_OP_W,
    parameter int DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [OP_W-1:0]            in_op,
    input  logic [DATA_W-1:0]          in_src1,
    input  logic [DATA_W-1:0]          in_src2,
    output logic                       alu_enable,
    output logic [OP_W-1:0]            alu_op,
    output logic [DATA_W-1:0]          alu_src1,
    output logic [DATA_W-1:0]          alu_src2,
    input  logic [DATA_W-1:0]          alu_result,
    input  logic                       alu_overflow,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DATA_W-1:0]          out_result,
    output logic                       out_overflow,
    output logic [OP_W-1:0]            out_op,
    output logic [$clog2(DEPTH+1)-1:0] level,
    output logic                       ovf_flag,
    input  logic                       ovf_clr
);
    localparam int LW = $clog2(DEPTH+1);
    alu_req_t req, head;
    logic empty, push, issue, halt;
    assign req        = '{op: in_op, src1: in_src1, src2: in_src2};
    assign empty      = level == '0;
    assign in_ready   = level < LW'(DEPTH);
    assign push       = in_valid && in_ready;
    assign issue      = !empty && (!out_valid || out_ready) && !halt;
    assign alu_enable = issue;
    assign alu_op     = empty ? '0 : head.op;
    assign alu_src1   = empty ? '0 : head.src1;
    assign alu_src2   = empty ? '0 : head.src2;
    alu_req_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (issue),
        .din   (req),
        .head  (head),
        .level (level)
    );
    // result register: capture the combinational ALU answer on issue, else drain on accept
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid    <= 1'b0;
            out_result   <= '0;
            out_overflow <= 1'b0;
            out_op       <= '0;
        end else if (issue) begin
            out_valid    <= 1'b1;
            out_result   <= alu_result;
            out_overflow <= alu_overflow;
            out_op       <= head.op;
        end else if (out_ready) begin
            out_valid    <= 1'b0;
        end
    end
`ifdef ALU_ISSUE_OVF_TRAP_EN
    assign halt = ovf_flag;
    // sticky trap: a captured overflow wins over a same-edge clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ovf_flag <= 1'b0;
        else if (issue && alu_overflow) ovf_flag <= 1'b1;
        else if (ovf_clr) ovf_flag <= 1'b0;
    end
`else
    logic unused_ovf_clr;
    assign unused_ovf_clr = ovf_clr;
    assign halt           = 1'b0;
    assign ovf_flag       = 1'b0;
`endif
endmodule

// File: tb/tb_alu_issue_stage.sv
// tb_alu_issue_stage: directed checks of the issue stage against a behavioural ALU
module tb_alu_issue_stage;
    import alu_pkg::*;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic        in_valid = 1'b0, in_ready;
    logic [3:0]  in_op = '0;
    logic [31:0] in_src1 = '0, in_src2 = '0;
    logic        alu_enable;
    logic [3:0]  alu_op;
    logic [31:0] alu_src1, alu_src2, alu_result;
    logic        alu_overflow;
    logic        out_valid, out_ready = 1'b1, out_overflow;
    logic [31:0] out_result;
    logic [3:0]  out_op;
    logic [2:0]  level;
    logic        ovf_flag, ovf_clr = 1'b0;
    int checks = 0, errors = 0;
    logic exp_flag;

    alu_issue_stage dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_src1(in_src1), .in_src2(in_src2),
        .alu_enable(alu_enable), .alu_op(alu_op), .alu_src1(alu_src1), .alu_src2(alu_src2),
        .alu_result(alu_result), .alu_overflow(alu_overflow),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_overflow(out_overflow), .out_op(out_op), .level(level),
        .ovf_flag(ovf_flag), .ovf_clr(ovf_clr)
    );

    always #5 clk = ~clk;

    // behavioural ALU: signed overflow on ADD/SUB, unknown opcodes yield 0
    always_comb begin
        alu_result   = '0;
        alu_overflow = 1'b0;
        case (alu_op)
            ALU_ADD: begin
                alu_result   = alu_src1 + alu_src2;
                alu_overflow = (alu_src1[31] == alu_src2[31]) && (alu_result[31] != alu_src1[31]);
            end
            ALU_SUB: begin
                alu_result   = alu_src1 - alu_src2;
                alu_overflow = (alu_src1[31] != alu_src2[31]) && (alu_result[31] != alu_src1[31]);
            end
            ALU_AND:    alu_result = alu_src1 & alu_src2;
            ALU_OR:     alu_result = alu_src1 | alu_src2;
            ALU_SLL:    alu_result = alu_src1 << alu_src2[4:0];
            ALU_ROTATE: alu_result = (alu_src1 << alu_src2[4:0]) | (alu_src1 >> (6'd32 - {1'b0, alu_src2[4:0]}));
            default:    alu_result = '0;
        endcase
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        in_valid = 1'b1;
        in_op    = op;
        in_src1  = a;
        in_src2  = b;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        chk({tag, "_level"}, 64'(level), 64'd0);
        chk({tag, "_alu_enable"}, 64'(alu_enable), 64'd0);
        chk({tag, "_alu_op"}, 64'(alu_op), 64'd0);
        chk({tag, "_alu_src1"}, 64'(alu_src1), 64'd0);
        chk({tag, "_alu_src2"}, 64'(alu_src2), 64'd0);
        chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
        chk({tag, "_out_result"}, 64'(out_result), 64'd0);
        chk({tag, "_out_overflow"}, 64'(out_overflow), 64'd0);
        chk({tag, "_out_op"}, 64'(out_op), 64'd0);
        chk({tag, "_ovf_flag"}, 64'(ovf_flag), 64'd0);
    endtask

    initial begin
`ifdef ALU_ISSUE_OVF_TRAP_EN
        exp_flag = 1'b1;
`else
        exp_flag = 1'b0;
`endif
        #2;
        chk_reset("rst");
        tick();
        rst_n = 1'b1;
        tick();

        set_req(ALU_ADD, 32'h3, 32'h9);
        tick();
        in_valid = 1'b0;
        chk("add_enable", 64'(alu_enable), 64'd1);
        chk("add_alu_src1", 64'(alu_src1), 64'h3);
        chk("add_valid_early", 64'(out_valid), 64'd0);
        tick();
        chk("add_valid", 64'(out_valid), 64'd1);
        chk("add_result", 64'(out_result), 64'hC);
        chk("add_ovf", 64'(out_overflow), 64'd0);
        chk("add_enable_off", 64'(alu_enable), 64'd0);
        tick();
        chk("add_drained", 64'(out_valid), 64'd0);

        set_req(ALU_SUB, 32'hCC, 32'hAA);
        tick();
        set_req(ALU_AND, 32'hE, 32'h7);
        tick();
        chk("b2b_sub", 64'(out_result), 64'h22);
        set_req(ALU_OR, 32'h5, 32'h2);
        tick();
        chk("b2b_and", 64'(out_result), 64'h6);
        set_req(ALU_SLL, 32'h1, 32'h1);
        tick();
        chk("b2b_or", 64'(out_result), 64'h7);
        in_valid = 1'b0;
        tick();
        chk("b2b_sll", 64'(out_result), 64'h2);
        chk("b2b_sll_op", 64'(out_op), 64'(ALU_SLL));
        chk("b2b_valid", 64'(out_valid), 64'd1);
        tick();
        chk("b2b_done", 64'(out_valid), 64'd0);

        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            set_req(ALU_ADD, 32'h10 + 32'(i), 32'h0);
            tick();
        end
        in_valid = 1'b0;
        chk("bp_level", 64'(level), 64'd4);
        chk("bp_in_ready", 64'(in_ready), 64'd0);
        chk("bp_out_valid", 64'(out_valid), 64'd1);
        chk("bp_first", 64'(out_result), 64'h10);
        chk("bp_enable_held", 64'(alu_enable), 64'd0);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("bp_drain%0d", i), 64'(out_result), 64'h11 + 64'(i));
        end
        tick();
        chk("bp_empty_valid", 64'(out_valid), 64'd0);
        chk("bp_empty_level", 64'(level), 64'd0);

        set_req(ALU_ADD, 32'h7FFF_FFFF, 32'h1);
        tick();
        in_valid = 1'b0;
        tick();
        chk("ovf_result", 64'(out_result), 64'h8000_0000);
        chk("ovf_out", 64'(out_overflow), 64'd1);
        chk("ovf_flag", 64'(ovf_flag), 64'(exp_flag));
        set_req(ALU_SUB, 32'h5, 32'h3);
        tick();
        in_valid = 1'b0;
`ifdef ALU_ISSUE_OVF_TRAP_EN
        tick();
        chk("trap_stall_en", 64'(alu_enable), 64'd0);
        chk("trap_stall_level", 64'(level), 64'd1);
        chk("trap_head_visible", 64'(alu_op), 64'(ALU_SUB));
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        chk("trap_cleared", 64'(ovf_flag), 64'd0);
        chk("trap_resume_en", 64'(alu_enable), 64'd1);
`endif
        tick();
        chk("post_ovf_result", 64'(out_result), 64'h2);
        chk("post_ovf_out", 64'(out_overflow), 64'd0);
        tick();

        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            set_req(ALU_OR, 32'h100 << i, 32'h0);
            tick();
        end
        in_valid = 1'b0;
        chk("mid_level", 64'(level), 64'd3);
        chk("mid_valid", 64'(out_valid), 64'd1);
        chk("mid_result", 64'(out_result), 64'h100);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset("midrst");
        out_ready = 1'b1;
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        chk("post_rst_valid", 64'(out_valid), 64'd0);
        chk("post_rst_level", 64'(level), 64'd0);
        chk("post_rst_result", 64'(out_result), 64'd0);

        set_req(4'hF, 32'h1, 32'h1);
        tick();
        in_valid = 1'b0;
        chk("opf_alu_op", 64'(alu_op), 64'hF);
        chk("opf_enable", 64'(alu_enable), 64'd1);
        tick();
        chk("opf_out_op", 64'(out_op), 64'hF);
        chk("opf_result", 64'(out_result), 64'd0);
        chk("opf_valid", 64'(out_valid), 64'd1);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
